// File: rtl/pwm_core_mc.sv
// pwm_core_mc: multi-channel PWM timer core behind a simple synchronous
// register port.
//   clk_i, rst_i        : single clock, synchronous active-high reset
//   wr_en_i, rd_en_i    : one-cycle write strobe, read strobe
//   addr_i, wdata_i     : word index and write data
//   rdata_o             : combinational read data (0 when idle or unmapped)
//   pwm_o               : registered per-channel PWM outputs
//   irq_o               : overflow interrupt (ovif & ovie)
// Counting is edge-aligned (sawtooth) or center-aligned (triangle). Period
// and duty registers are double-buffered so that changes take effect at a
// period boundary.
module pwm_core_mc #(
  parameter int CHN_NUM    = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int PSCR_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  input  logic [4:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic [CHN_NUM-1:0] pwm_o,
  output logic               irq_o
);

  localparam logic [4:0] ADDR_CTRL = 5'd0;
  localparam logic [4:0] ADDR_PSCR = 5'd1;
  localparam logic [4:0] ADDR_CMP  = 5'd2;
  localparam logic [4:0] ADDR_STAT = 5'd3;
  localparam logic [4:0] ADDR_POL  = 5'd4;
  localparam logic [4:0] ADDR_CNT  = 5'd5;
  localparam int         ADDR_CR0  = 8;

  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PSCR_WIDTH-1:0] PSC_ONE = PSCR_WIDTH'(1);

  logic                  ovie_q, ovie_d;
  logic                  en_q, en_d;
  logic                  cmode_q, cmode_d;
  logic                  ovif_q, ovif_d;
  logic [0:0]            dir_q, dir_d;
  logic [PSCR_WIDTH-1:0] pscr_q, pscr_d;
  logic [PSCR_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_WIDTH-1:0]  cmp_pre_q, cmp_pre_d;
  logic [CNT_WIDTH-1:0]  cmp_act_q, cmp_act_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CHN_NUM-1:0]    pol_q, pol_d;
  logic [CHN_NUM-1:0]    pwm_q, pwm_d;
  logic [CNT_WIDTH-1:0]  cr_pre_q [CHN_NUM];
  logic [CNT_WIDTH-1:0]  cr_pre_d [CHN_NUM];
  logic [CNT_WIDTH-1:0]  cr_act_q [CHN_NUM];
  logic [CNT_WIDTH-1:0]  cr_act_d [CHN_NUM];

  logic wr_ctrl, clr, tick, upd;

  // Only the low bits of wdata_i are meaningful for most registers.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  assign wr_ctrl = wr_en_i && (addr_i == ADDR_CTRL);
  assign clr     = wr_ctrl && wdata_i[2];
  assign tick    = en_q && (psc_cnt_q >= pscr_q);

  always_comb begin
    ovie_d    = ovie_q;
    en_d      = en_q;
    cmode_d   = cmode_q;
    ovif_d    = ovif_q;
    dir_d     = dir_q;
    pscr_d    = pscr_q;
    psc_cnt_d = psc_cnt_q;
    cmp_pre_d = cmp_pre_q;
    cmp_act_d = cmp_act_q;
    cnt_d     = cnt_q;
    pol_d     = pol_q;
    pwm_d     = pwm_q;
    cr_pre_d  = cr_pre_q;
    cr_act_d  = cr_act_q;
    upd       = 1'b0;

    // Register port writes
    if (wr_en_i) begin
      case (addr_i)
        ADDR_CTRL: begin
          ovie_d  = wdata_i[0];
          en_d    = wdata_i[1];
          cmode_d = wdata_i[3];
        end
        ADDR_PSCR: pscr_d    = wdata_i[PSCR_WIDTH-1:0];
        ADDR_CMP:  cmp_pre_d = wdata_i[CNT_WIDTH-1:0];
        ADDR_POL:  pol_d     = wdata_i[CHN_NUM-1:0];
        default: begin
          for (int k = 0; k < CHN_NUM; k++) begin
            if (addr_i == 5'(ADDR_CR0 + k)) cr_pre_d[k] = wdata_i[CNT_WIDTH-1:0];
          end
        end
      endcase
    end

    // Prescaler: free-runs 0..PSCR while enabled, parked at 0 otherwise.
    if (!en_q || tick) psc_cnt_d = '0;
    else               psc_cnt_d = psc_cnt_q + PSC_ONE;

    // Counter step. CMP of 0 (and 1 in center mode) degenerates to a
    // counter stuck at 0 where every tick is a period boundary.
    if (tick && !clr) begin
      if (!cmode_q) begin
        if (cmp_act_q == '0 || cnt_q >= cmp_act_q - CNT_ONE) begin
          cnt_d = '0;
          upd   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (cmp_act_q <= CNT_ONE) begin
        cnt_d = '0;
        dir_d = DIR_UP;
        upd   = 1'b1;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= cmp_act_q - CNT_ONE) begin
          dir_d = DIR_DN;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          dir_d = DIR_UP;
          cnt_d = cnt_q + CNT_ONE;
          upd   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end

    if (clr) begin
      cnt_d     = '0;
      dir_d     = DIR_UP;
      psc_cnt_d = '0;
    end

    // Shadows track the preload continuously while stopped so that a
    // restart always begins with the programmed values.
    if (upd || clr || !en_q) begin
      cmp_act_d = cmp_pre_q;
      cr_act_d  = cr_pre_q;
    end

    // Set has priority over a simultaneous write-1-to-clear.
    if (wr_en_i && addr_i == ADDR_STAT && wdata_i[0]) ovif_d = 1'b0;
    if (upd && ovie_q) ovif_d = 1'b1;

    for (int k = 0; k < CHN_NUM; k++) begin
      pwm_d[k] = en_q ? ((cnt_q < cr_act_q[k]) ^ pol_q[k]) : pol_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovie_q    <= 1'b0;
      en_q      <= 1'b0;
      cmode_q   <= 1'b0;
      ovif_q    <= 1'b0;
      dir_q     <= DIR_UP;
      pscr_q    <= '0;
      psc_cnt_q <= '0;
      cmp_pre_q <= '0;
      cmp_act_q <= '0;
      cnt_q     <= '0;
      pol_q     <= '0;
      pwm_q     <= '0;
      for (int k = 0; k < CHN_NUM; k++) begin
        cr_pre_q[k] <= '0;
        cr_act_q[k] <= '0;
      end
    end else begin
      ovie_q    <= ovie_d;
      en_q      <= en_d;
      cmode_q   <= cmode_d;
      ovif_q    <= ovif_d;
      dir_q     <= dir_d;
      pscr_q    <= pscr_d;
      psc_cnt_q <= psc_cnt_d;
      cmp_pre_q <= cmp_pre_d;
      cmp_act_q <= cmp_act_d;
      cnt_q     <= cnt_d;
      pol_q     <= pol_d;
      pwm_q     <= pwm_d;
      cr_pre_q  <= cr_pre_d;
      cr_act_q  <= cr_act_d;
    end
  end

  // Read mux: CMP/CRk return the preload copy; clr always reads 0.
  always_comb begin
    rdata_o = '0;
    if (rd_en_i) begin
      case (addr_i)
        ADDR_CTRL: rdata_o = {28'd0, cmode_q, 1'b0, en_q, ovie_q};
        ADDR_PSCR: rdata_o = 32'(pscr_q);
        ADDR_CMP:  rdata_o = 32'(cmp_pre_q);
        ADDR_STAT: rdata_o = {31'd0, ovif_q};
        ADDR_POL:  rdata_o = 32'(pol_q);
        ADDR_CNT:  rdata_o = 32'(cnt_q);
        default: begin
          for (int k = 0; k < CHN_NUM; k++) begin
            if (addr_i == 5'(ADDR_CR0 + k)) rdata_o = 32'(cr_pre_q[k]);
          end
        end
      endcase
    end
  end

  assign pwm_o = pwm_q;
  assign irq_o = ovif_q & ovie_q;

endmodule
